// File: rtl/id_ex_register_pkg.sv
// Shared widths, bubble encodings and register-group types for the ID/EX pipeline register.
package id_ex_register_pkg;

   localparam int unsigned ExW    = 2;
   localparam int unsigned MemW   = 3;
   localparam int unsigned WbW    = 2;
   localparam int unsigned DataW  = 32;
   localparam int unsigned RegW   = 5;
   localparam int unsigned FunctW = 10;
   localparam int unsigned CntW   = 16;

   localparam logic [ExW-1:0]  ExBubble  = '0;
   localparam logic [MemW-1:0] MemBubble = '0;
   localparam logic [WbW-1:0]  WbBubble  = '0;

   typedef enum logic [1:0] {
      ActLoad,
      ActHold,
      ActBubble
   } action_e;

   typedef struct packed {
      logic [ExW-1:0]  ex;
      logic [MemW-1:0] mem;
      logic [WbW-1:0]  wb;
      logic            valid;
   } ctrl_t;

   typedef struct packed {
      logic [DataW-1:0]  rs1_data;
      logic [DataW-1:0]  rs2_data;
      logic [DataW-1:0]  imm;
      logic [FunctW-1:0] funct;
      logic [RegW-1:0]   rs1_addr;
      logic [RegW-1:0]   rs2_addr;
      logic [RegW-1:0]   rd_addr;
   } data_t;

   localparam ctrl_t CtrlBubble = '{ex: ExBubble, mem: MemBubble, wb: WbBubble, valid: 1'b0};

   // Flush outranks stall so a squashed instruction can never be frozen in EX.
   function automatic action_e next_action(input logic flush, input logic stall);
      if (flush) begin
         return ActBubble;
      end else if (stall) begin
         return ActHold;
      end
      return ActLoad;
   endfunction

endpackage

// File: rtl/bubble_counter.sv
// Saturating count of bubbles entering EX; sticks at all-ones instead of wrapping.
module bubble_counter
   import id_ex_register_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc_i,
   output logic [CntW-1:0] cnt_o
);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CntW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: load, hold or bubble each cycle, with a saturating bubble count.
module id_ex_register
   import id_ex_register_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [ExW-1:0]    EX_signal_i,
   input  logic [MemW-1:0]   MEM_signal_i,
   input  logic [WbW-1:0]    WB_signal_i,
   input  logic [DataW-1:0]  RS1data_i,
   input  logic [DataW-1:0]  RS2data_i,
   input  logic [DataW-1:0]  imm_i,
   input  logic [FunctW-1:0] funct_i,
   input  logic [RegW-1:0]   RS1addr_i,
   input  logic [RegW-1:0]   RS2addr_i,
   input  logic [RegW-1:0]   RDaddr_i,
   output logic [ExW-1:0]    EX_signal_o,
   output logic [MemW-1:0]   MEM_signal_o,
   output logic [WbW-1:0]    WB_signal_o,
   output logic [DataW-1:0]  RS1data_o,
   output logic [DataW-1:0]  RS2data_o,
   output logic [DataW-1:0]  imm_o,
   output logic [FunctW-1:0] funct_o,
   output logic [RegW-1:0]   RS1addr_o,
   output logic [RegW-1:0]   RS2addr_o,
   output logic [RegW-1:0]   RDaddr_o,
   output logic              valid_o,
   output logic [CntW-1:0]   bubble_cnt_o
);

   action_e action;
   ctrl_t   ctrl_d, ctrl_q;
   data_t   data_d, data_q;
   logic    bubble_inc;

   assign action     = next_action(flush_i, stall_i);
   assign bubble_inc = (action == ActBubble) || ((action == ActLoad) && !valid_i);

   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      case (action)
         ActBubble: begin
            ctrl_d = CtrlBubble;
            data_d = '0;
         end
         ActLoad: begin
            ctrl_d.valid    = valid_i;
            ctrl_d.ex       = valid_i ? EX_signal_i  : ExBubble;
            ctrl_d.mem      = valid_i ? MEM_signal_i : MemBubble;
            ctrl_d.wb       = valid_i ? WB_signal_i  : WbBubble;
            data_d.rs1_data = RS1data_i;
            data_d.rs2_data = RS2data_i;
            data_d.imm      = imm_i;
            data_d.funct    = funct_i;
            data_d.rs1_addr = RS1addr_i;
            data_d.rs2_addr = RS2addr_i;
            // A non-valid instruction must never look like a forwarding source.
            data_d.rd_addr  = valid_i ? RDaddr_i : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q <= CtrlBubble;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   bubble_counter u_bubble_counter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (bubble_inc),
      .cnt_o (bubble_cnt_o)
   );

   assign EX_signal_o  = ctrl_q.ex;
   assign MEM_signal_o = ctrl_q.mem;
   assign WB_signal_o  = ctrl_q.wb;
   assign valid_o      = ctrl_q.valid;
   assign RS1data_o    = data_q.rs1_data;
   assign RS2data_o    = data_q.rs2_data;
   assign imm_o        = data_q.imm;
   assign funct_o      = data_q.funct;
   assign RS1addr_o    = data_q.rs1_addr;
   assign RS2addr_o    = data_q.rs2_addr;
   assign RDaddr_o     = data_q.rd_addr;

endmodule
